alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Execute-stage initiator for the 16-bit ALU. It accepts one decoded operation from decode over a valid/ready handshake and drives the ALU operand and opsel inputs, holding them stable until the ALU asserts ready. It then captures the result, extra result and flag_next, owns the architectural ZNCO flag register, and presents a writeback beat to the register file.

Parameters:
DST_W, 3, destination register index width
TIMEOUT_CYCLES, 64, EXEC cycles before abort (only with ALU_EXEC_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  decode has an operation
req_ready  out  1  controller can accept
req_op  in  5  ALU opsel code (shared opsel constants)
req_a / req_b / req_x  in  16 each  srcA, srcB, extra_X operands
req_dst  in  DST_W  destination register
req_setf  in  1  commit flags on completion
alu_srcA / alu_srcB / alu_extra_X  out  16 each  ALU operands
alu_opsel  out  5  ALU operation select
alu_Cflag / alu_Oflag  out  1 each  current C/O flags to ALU
alu_res / alu_extra_res  in  16 each  ALU results
alu_ready  in  1  ALU result valid
alu_flag_next  in  4  {Z,N,C,O} from ALU
wb_valid  out  1  writeback beat valid
wb_ready  in  1  register file accepts
wb_dst  out  DST_W  writeback register
wb_data / wb_extra  out  16 each  result, high/extra result
wb_extra_en  out  1  wb_extra is meaningful (MUL, DIV, POW)
flags  out  4  architectural {Z,N,C,O}, bit3=Z … bit0=O
busy  out  1  state != IDLE
timeout  out  1  sticky abort indicator (feature only; else tied 0)

Behaviour:
- Reset: state IDLE; flags=0; wb_valid=0; req_ready=1; busy=0; alu_opsel=ALU_SHORT_B; operand registers, wb_data, wb_extra, wb_dst =0.
- States: IDLE, EXEC, WB.
- IDLE: req_ready=1. On req_valid, latch op/a/b/x/dst/setf and go to EXEC.
- EXEC: alu_opsel=latched op; operands held constant; req_ready=0.
  - Non-POW op: on alu_ready=1, capture res, extra_res and flag_next, then go to WB.
  - ALU_POW: alu_ready is ignored on the first EXEC cycle (guards against a stale ready); it is honoured from the second cycle on.
- Flag commit: on the EXEC→WB edge, if setf=1 then flags<=alu_flag_next, else flags are unchanged. alu_Cflag=flags[1] and alu_Oflag=flags[0] are always taken from the register, never from the pending result.
- WB: wb_valid=1; all wb_* outputs held stable until wb_ready=1, then go to IDLE. wb_extra_en=1 only for ALU_MUL, ALU_DIV and ALU_POW.
- Latency: request accepted in cycle 0 → wb_valid in cycle 2 for single-cycle ops; POW takes 2 + pow cycles. Throughput is one op per 3 cycles minimum; there is no overlap.
- Outside EXEC, alu_opsel=ALU_SHORT_B. This guarantees at least two non-POW cycles between back-to-back POWs, so the level-triggered pow start re-arms.
- req_valid while busy: ignored, since req_ready=0.
- Reset mid-EXEC or mid-WB: returns to IDLE immediately; the in-flight op is dropped; flags clear.
- Width: all datapaths are 16-bit; there is no arithmetic in this block.

Optional Feature:
ALU_EXEC_TIMEOUT_EN.
- Defined: a counter runs in EXEC. When it reaches TIMEOUT_CYCLES without a qualifying alu_ready, the controller goes to WB with wb_data=0xFFFF, wb_extra=0xFFFF and wb_extra_en=0; flags are not committed; timeout is set sticky until reset.
- Undefined: no counter; EXEC waits indefinitely; timeout is tied 0.

Decomposition:
- Shared package/include: opsel codes (existing opsel include), flag bit indices ZF=3/NF=2/CF=1/OF=0, and state encoding localparams.
- A helper function is_extra_op(op) also goes in the shared package.
- No sub-module; the optional timeout counter stays inline.

Test Plan:
- ADD 0x7FFF+0x0001, setf=1, ALU model ready=1 → wb_valid in cycle 2; wb_data=0x8000; flags=4'b0101; wb_extra_en=0.
- MUL 0x0100×0x0100 → wb_data=0x0000, wb_extra=0x0001, wb_extra_en=1; with setf=0, flags are unchanged from their prior value.
- POW with model ready=1 on EXEC cycle 1 and then low for 4 cycles → first-cycle ready ignored; wb_valid appears 1 cycle after ready returns; a second POW issued immediately sees alu_opsel≠POW for ≥2 cycles between the two.
- wb_ready held low 3 cycles → wb_* stable, req_ready=0, and a req_valid pulse is not accepted; accepted on the cycle after wb_ready=1.
- rst asserted mid-EXEC of a POW → within the same cycle: busy=0, flags=0, alu_opsel=ALU_SHORT_B; no wb_valid afterward.
- ALU_EXEC_TIMEOUT_EN with TIMEOUT_CYCLES=8 and ready never asserted → wb_data=0xFFFF after 8 EXEC cycles; timeout=1; flags unchanged.

Source files
------------

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU execute-stage controller: opsel codes, flag bit
// indices, FSM state encodings and the extra-result helper.
package alu_exec_ctrl_pkg;

    localparam logic [4:0] ALU_ADD     = 5'h00;
    localparam logic [4:0] ALU_SUB     = 5'h01;
    localparam logic [4:0] ALU_AND     = 5'h02;
    localparam logic [4:0] ALU_OR      = 5'h03;
    localparam logic [4:0] ALU_XOR     = 5'h04;
    localparam logic [4:0] ALU_SHL     = 5'h05;
    localparam logic [4:0] ALU_SHR     = 5'h06;
    localparam logic [4:0] ALU_MUL     = 5'h08;
    localparam logic [4:0] ALU_DIV     = 5'h09;
    localparam logic [4:0] ALU_POW     = 5'h0A;
    localparam logic [4:0] ALU_SHORT_B = 5'h1F;

    localparam int ZF = 3;
    localparam int NF = 2;
    localparam int CF = 1;
    localparam int OF = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Ops whose high/extra result word carries meaning for writeback.
    function automatic logic is_extra_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_POW);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the decode request, ALU operand/result and writeback channels seen by
// the execute-stage controller; master = controller side, slave = environment side.
interface alu_exec_ctrl_if #(parameter int DST_W = 3);

    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [15:0]      req_a;
    logic [15:0]      req_b;
    logic [15:0]      req_x;
    logic [DST_W-1:0] req_dst;
    logic             req_setf;

    logic [15:0]      alu_srcA;
    logic [15:0]      alu_srcB;
    logic [15:0]      alu_extra_X;
    logic [4:0]       alu_opsel;
    logic             alu_Cflag;
    logic             alu_Oflag;
    logic [15:0]      alu_res;
    logic [15:0]      alu_extra_res;
    logic             alu_ready;
    logic [3:0]       alu_flag_next;

    logic             wb_valid;
    logic             wb_ready;
    logic [DST_W-1:0] wb_dst;
    logic [15:0]      wb_data;
    logic [15:0]      wb_extra;
    logic             wb_extra_en;

    logic [3:0]       flags;
    logic             busy;
    logic             timeout;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_x, req_dst, req_setf,
        output req_ready,
        output alu_srcA, alu_srcB, alu_extra_X, alu_opsel, alu_Cflag, alu_Oflag,
        input  alu_res, alu_extra_res, alu_ready, alu_flag_next,
        output wb_valid, wb_dst, wb_data, wb_extra, wb_extra_en,
        input  wb_ready,
        output flags, busy, timeout
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_x, req_dst, req_setf,
        input  req_ready,
        input  alu_srcA, alu_srcB, alu_extra_X, alu_opsel, alu_Cflag, alu_Oflag,
        output alu_res, alu_extra_res, alu_ready, alu_flag_next,
        input  wb_valid, wb_dst, wb_data, wb_extra, wb_extra_en,
        output wb_ready,
        input  flags, busy, timeout
    );

endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage initiator for the 16-bit ALU: IDLE -> EXEC -> WB, owns the ZNCO flags.
// Optional EXEC watchdog enabled by defining ALU_EXEC_TIMEOUT_EN.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DST_W = 3
`ifdef ALU_EXEC_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input logic            clk,
    input logic            rst,
    alu_exec_ctrl_if.master bus
);

    logic [1:0]       state;
    logic [4:0]       op_q;
    logic [15:0]      a_q, b_q, x_q;
    logic [DST_W-1:0] dst_q;
    logic             setf_q;
    logic             exec_first;
    logic [15:0]      wb_data_q, wb_extra_q;
    logic             wb_extra_en_q;
    logic [3:0]       flags_q;
    logic             done;
    logic             expired;

    // A POW may see a stale ready left over from the previous op on its first EXEC cycle.
    assign done = (state == ST_EXEC) && bus.alu_ready && !(exec_first && (op_q == ALU_POW));

`ifdef ALU_EXEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] exec_cnt;
    logic             timeout_q;

    assign expired = (state == ST_EXEC) && !done && (exec_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exec_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (state != ST_EXEC) begin
            exec_cnt <= '0;
        end else begin
            exec_cnt <= exec_cnt + 1'b1;
            if (expired) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            op_q          <= ALU_SHORT_B;
            a_q           <= '0;
            b_q           <= '0;
            x_q           <= '0;
            dst_q         <= '0;
            setf_q        <= 1'b0;
            exec_first    <= 1'b0;
            wb_data_q     <= '0;
            wb_extra_q    <= '0;
            wb_extra_en_q <= 1'b0;
            flags_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q       <= bus.req_op;
                        a_q        <= bus.req_a;
                        b_q        <= bus.req_b;
                        x_q        <= bus.req_x;
                        dst_q      <= bus.req_dst;
                        setf_q     <= bus.req_setf;
                        exec_first <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    exec_first <= 1'b0;
                    if (done) begin
                        wb_data_q     <= bus.alu_res;
                        wb_extra_q    <= bus.alu_extra_res;
                        wb_extra_en_q <= is_extra_op(op_q);
                        if (setf_q) flags_q <= bus.alu_flag_next;
                        state         <= ST_WB;
                    end else if (expired) begin
                        wb_data_q     <= 16'hFFFF;
                        wb_extra_q    <= 16'hFFFF;
                        wb_extra_en_q <= 1'b0;
                        state         <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (bus.wb_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Parking opsel on SHORT_B outside EXEC lets the ALU's level-triggered POW start re-arm.
    assign bus.alu_opsel   = (state == ST_EXEC) ? op_q : ALU_SHORT_B;
    assign bus.alu_srcA    = a_q;
    assign bus.alu_srcB    = b_q;
    assign bus.alu_extra_X = x_q;
    assign bus.alu_Cflag   = flags_q[CF];
    assign bus.alu_Oflag   = flags_q[OF];

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.wb_valid    = (state == ST_WB);
    assign bus.wb_dst      = dst_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_extra    = wb_extra_q;
    assign bus.wb_extra_en = wb_extra_en_q;
    assign bus.flags       = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed ops push expected writeback beats,
// an independent negedge monitor pops and compares them against the DUT.
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] data;
        logic [15:0] extra;
        logic        en;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    alu_exec_ctrl_if #(.DST_W(3)) bus ();

    alu_exec_ctrl #(
        .DST_W(3)
`ifdef ALU_EXEC_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Minimal ALU: ADD, MUL and POW are modelled; anything else passes srcB through.
    function automatic logic [31:0] pow32(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p = 32'd1;
        for (int i = 0; i < 16; i++) if (i < int'(b)) p = p * {16'd0, a};
        return p;
    endfunction

    logic alu_ready_drv;
    always_comb begin
        logic [16:0] s;
        logic [31:0] p;
        bus.alu_res       = bus.alu_srcB;
        bus.alu_extra_res = 16'h0000;
        bus.alu_flag_next = 4'b0000;
        bus.alu_ready     = alu_ready_drv;
        s = 17'd0;
        p = 32'd0;
        case (bus.alu_opsel)
            ALU_ADD: begin
                s = {1'b0, bus.alu_srcA} + {1'b0, bus.alu_srcB};
                bus.alu_res = s[15:0];
                bus.alu_flag_next = {s[15:0] == 16'd0, s[15], s[16],
                                     (bus.alu_srcA[15] == bus.alu_srcB[15]) && (s[15] != bus.alu_srcA[15])};
            end
            ALU_MUL, ALU_POW: begin
                p = (bus.alu_opsel == ALU_MUL) ? bus.alu_srcA * bus.alu_srcB : pow32(bus.alu_srcA, bus.alu_srcB);
                bus.alu_res       = p[15:0];
                bus.alu_extra_res = p[31:16];
                bus.alu_flag_next = {p[15:0] == 16'd0, p[15], p[31:16] != 16'd0, 1'b0};
            end
            default: ;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    int          ncyc = 0;
    int          acc_cyc = 0;
    int          lat_meas = 0;
    bit          wv_prev = 0;
    bit          hold_pending = 0;
    logic [2:0]  held_dst;
    logic [15:0] held_data, held_extra;
    logic        held_en;
    bit          seen_pow = 0;
    bit          prev_pow = 0;
    int          pow_gap = 0;

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (bus.req_valid && bus.req_ready && !rst) acc_cyc = ncyc;
        if (bus.wb_valid && !wv_prev) lat_meas = ncyc - acc_cyc;
        if (hold_pending && bus.wb_valid) begin
            check("hold_dst",   bus.wb_dst,      held_dst);
            check("hold_data",  bus.wb_data,     held_data);
            check("hold_extra", bus.wb_extra,    held_extra);
            check("hold_en",    bus.wb_extra_en, held_en);
        end
        hold_pending = 0;
        if (bus.wb_valid) begin
            if (bus.wb_ready) begin
                if (sb.size() == 0) begin
                    check("wb_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("wb_dst",      bus.wb_dst,      e.dst);
                    check("wb_data",     bus.wb_data,     e.data);
                    check("wb_extra",    bus.wb_extra,    e.extra);
                    check("wb_extra_en", bus.wb_extra_en, e.en);
                    check("flags",       bus.flags,       e.flags);
                    if (e.lat != 0) check("latency", lat_meas, e.lat);
                end
            end else begin
                hold_pending = 1;
                held_dst   = bus.wb_dst;
                held_data  = bus.wb_data;
                held_extra = bus.wb_extra;
                held_en    = bus.wb_extra_en;
            end
        end
        wv_prev = bus.wb_valid;
        if (bus.alu_opsel == ALU_POW) begin
            if (seen_pow && !prev_pow) check("pow_gap_ge2", pow_gap >= 2, 1);
            seen_pow = 1;
            prev_pow = 1;
            pow_gap  = 0;
        end else begin
            prev_pow = 0;
            pow_gap++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_wb(input logic [2:0] dst, input logic [15:0] data, input logic [15:0] extra,
                             input logic en, input logic [3:0] fl, input int lat);
        exp_t e;
        e.dst = dst; e.data = data; e.extra = extra; e.en = en; e.flags = fl; e.lat = lat;
        sb.push_back(e);
    endtask

    // Returns #1 into the first EXEC cycle of the accepted op.
    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] dst, input logic setf);
        int n = 0;
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_x = 16'h00A5;
        bus.req_dst = dst; bus.req_setf = setf; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("accept_wait", n, 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Ready high on EXEC cycle 1 (stale), low for 4 cycles, high again on cycle 6.
    task automatic issue_pow(input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst, input logic setf);
        alu_ready_drv = 1'b1;
        issue(ALU_POW, a, b, dst, setf);
        @(posedge clk); #1;
        alu_ready_drv = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        alu_ready_drv = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = ALU_ADD; bus.req_a = '0; bus.req_b = '0;
        bus.req_x = '0; bus.req_dst = '0; bus.req_setf = 1'b0;
        bus.wb_ready = 1'b1;
        alu_ready_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy",      bus.busy,      0);
        check("rst_wb_valid",  bus.wb_valid,  0);
        check("rst_flags",     bus.flags,     0);
        check("rst_opsel",     bus.alu_opsel, ALU_SHORT_B);
        check("rst_srcA",      bus.alu_srcA,  0);
        check("rst_wb_data",   bus.wb_data,   0);
        check("rst_wb_dst",    bus.wb_dst,    0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD overflow into sign bit, flags committed: Z0 N1 C0 O1
        expect_wb(3'd1, 16'h8000, 16'h0000, 1'b0, 4'b0101, 2);
        issue(ALU_ADD, 16'h7FFF, 16'h0001, 3'd1, 1'b1);

        // MUL with setf=0 and a 3-cycle writeback stall
        expect_wb(3'd2, 16'h0000, 16'h0001, 1'b1, 4'b0101, 2);
        issue(ALU_MUL, 16'h0100, 16'h0100, 3'd2, 1'b0);
        check("exec_opsel", bus.alu_opsel, ALU_MUL);
        check("exec_srcA",  bus.alu_srcA,  16'h0100);
        check("exec_Cflag", bus.alu_Cflag, 0);
        check("exec_Oflag", bus.alu_Oflag, 1);
        bus.wb_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_wb_valid",  bus.wb_valid,  1);
        check("stall_req_ready", bus.req_ready, 0);
        bus.req_op = ALU_ADD; bus.req_a = 16'h5555; bus.req_dst = 3'd6; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("stall_req_ready2", bus.req_ready, 0);
        check("stall_busy",       bus.busy,      1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;

        // Accepted in the IDLE cycle right after the stalled beat completes
        expect_wb(3'd3, 16'h1235, 16'h0000, 1'b0, 4'b0101, 2);
        issue(ALU_ADD, 16'h1234, 16'h0001, 3'd3, 1'b0);

        // Back-to-back POWs: stale ready ignored, result one cycle after ready returns
        expect_wb(3'd4, 16'h8000, 16'h0000, 1'b1, 4'b0100, 7);
        issue_pow(16'd2, 16'd15, 3'd4, 1'b1);
        expect_wb(3'd5, 16'h001B, 16'h0000, 1'b1, 4'b0100, 7);
        issue_pow(16'd3, 16'd3, 3'd5, 1'b0);

        // Reset in the middle of a POW's EXEC: dropped, flags cleared at once
        issue(ALU_POW, 16'd2, 16'd2, 3'd6, 1'b1);
        alu_ready_drv = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",     bus.busy,      0);
        check("mid_rst_flags",    bus.flags,     0);
        check("mid_rst_opsel",    bus.alu_opsel, ALU_SHORT_B);
        check("mid_rst_wb_valid", bus.wb_valid,  0);
        @(posedge clk); #1;
        rst = 1'b0;
        alu_ready_drv = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("post_rst_wb_valid", bus.wb_valid, 0);

        // ADD wrapping to zero with carry and overflow: Z1 N0 C1 O1
        expect_wb(3'd7, 16'h0000, 16'h0000, 1'b0, 4'b1011, 2);
        issue(ALU_ADD, 16'h8000, 16'h8000, 3'd7, 1'b1);
        repeat (3) begin @(posedge clk); #1; end

`ifdef ALU_EXEC_TIMEOUT_EN
        // ALU never ready: aborted after 8 EXEC cycles, flags untouched
        alu_ready_drv = 1'b0;
        expect_wb(3'd1, 16'hFFFF, 16'hFFFF, 1'b0, 4'b1011, 9);
        issue(ALU_ADD, 16'h0001, 16'h0002, 3'd1, 1'b1);
        repeat (12) begin @(posedge clk); #1; end
        check("timeout_sticky", bus.timeout, 1);
        alu_ready_drv = 1'b1;
`else
        check("timeout_tied0", bus.timeout, 0);
`endif

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
